// File: rtl/clockgate_result_accum_pkg.sv
// Shared definitions for the frame-statistics accumulator that sits behind
// the (a+-b)*c datapath.
//   DW    : width of one incoming result
//   N_DEF : default samples per full frame
//   state_e : two-state frame FSM encoding (collecting / holding a result)
package clockgate_result_accum_pkg;
    localparam int DW    = 16;
    localparam int N_DEF = 8;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/clockgate_result_accum_if.sv
// Handshake bundle for the frame accumulator.
//   in_valid/in_data/in_ready : sample stream from the upstream datapath
//   flush                     : one-cycle request to close a partial frame
//   out_valid/out_ready       : frame result handshake
//   out_sum/out_max/out_zero/out_cnt : per-frame statistics
// Modports: slave = the accumulator, master = its environment.
interface clockgate_result_accum_if #(
    parameter int DW = 16,
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1),
    parameter int AW = DW + $clog2(N)
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [DW-1:0] out_max;
    logic [CW-1:0] out_zero;
    logic [CW-1:0] out_cnt;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_zero, out_cnt
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_zero, out_cnt
    );
endinterface

// File: rtl/clockgate_result_accum_stats.sv
// Per-frame statistics registers: running sum, maximum, zero count and
// sample count. Updated on acc_i, cleared on clr_i (clear has priority).
//   clk, reset : clock, asynchronous active-low reset
//   acc_i      : fold data_i into the statistics this edge
//   clr_i      : return all statistics to zero this edge
//   data_i     : incoming sample
//   sum_o/max_o/zero_o/cnt_o : registered statistics
module clockgate_result_accum_stats #(
    parameter int DW = 16,
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1),
    parameter int AW = DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acc_i,
    input  logic          clr_i,
    input  logic [DW-1:0] data_i,
    output logic [AW-1:0] sum_o,
    output logic [DW-1:0] max_o,
    output logic [CW-1:0] zero_o,
    output logic [CW-1:0] cnt_o
);
    logic [AW-1:0] sum_q,  sum_d;
    logic [DW-1:0] max_q,  max_d;
    logic [CW-1:0] zero_q, zero_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        sum_d  = sum_q;
        max_d  = max_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            sum_d  = '0;
            max_d  = '0;
            zero_d = '0;
            cnt_d  = '0;
        end else if (acc_i) begin
            // AW leaves room for N full-scale samples, so no wrap is possible
            sum_d  = sum_q + AW'(data_i);
            max_d  = (data_i > max_q) ? data_i : max_q;
            zero_d = zero_q + CW'(data_i == '0);
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q  <= '0;
            max_q  <= '0;
            zero_q <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            max_q  <= max_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sum_o  = sum_q;
    assign max_o  = max_q;
    assign zero_o = zero_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/clockgate_result_accum.sv
// Frame accumulator for the 16-bit results of the (a+-b)*c datapath.
// Collects up to N samples per frame (or fewer when flushed) and presents
// sum, max, zero-count and sample count until the consumer takes them.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of clockgate_result_accum_if (input stream, flush,
//           frame result handshake)
module clockgate_result_accum
    import clockgate_result_accum_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N + 1),
    parameter int AW = DW + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    clockgate_result_accum_if.slave  bus
);
    state_e        state_q, state_d;
    logic          acc, clr;
    logic [AW-1:0] sum;
    logic [DW-1:0] max;
    logic [CW-1:0] zero;
    logic [CW-1:0] cnt;

    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_ACC: begin
                acc = bus.in_valid;
                if (acc && cnt == CW'(N - 1)) begin
                    state_d = ST_HOLD;
                end else if (bus.flush && (acc || cnt != '0)) begin
                    // an empty frame is never closed; a same-cycle sample
                    // counts toward the flushed frame
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // no bypass: the slot freed by the handshake opens next cycle
                if (bus.out_ready) begin
                    clr     = 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    clockgate_result_accum_stats #(
        .DW (DW),
        .N  (N),
        .CW (CW),
        .AW (AW)
    ) u_stats (
        .clk    (clk),
        .reset  (reset),
        .acc_i  (acc),
        .clr_i  (clr),
        .data_i (bus.in_data),
        .sum_o  (sum),
        .max_o  (max),
        .zero_o (zero),
        .cnt_o  (cnt)
    );

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_sum   = sum;
    assign bus.out_max   = max;
    assign bus.out_zero  = zero;
    assign bus.out_cnt   = cnt;
endmodule

// File: tb/tb_clockgate_result_accum.sv
module tb_clockgate_result_accum;
    logic clk = 1'b0;
    logic reset;
    int   errs  = 0;
    int   total = 0;

    always #5 clk = ~clk;

    clockgate_result_accum_if #(.DW(16), .N(8)) bus ();

    clockgate_result_accum #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] s, input logic [31:0] m,
                             input logic [31:0] z, input logic [31:0] c);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".rdy"},   32'(bus.in_ready),  32'd0);
        chk({tag, ".sum"},   32'(bus.out_sum),   s);
        chk({tag, ".max"},   32'(bus.out_max),   m);
        chk({tag, ".zero"},  32'(bus.out_zero),  z);
        chk({tag, ".cnt"},   32'(bus.out_cnt),   c);
    endtask

    // complete the handshake, then confirm the block is collecting again
    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".hs_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".hs_rdy"},   32'(bus.in_ready),  32'd1);
    endtask

    logic [18:0] held_sum;

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.sum",   32'(bus.out_sum),   32'd0);
        chk("rst.max",   32'(bus.out_max),   32'd0);
        chk("rst.zero",  32'(bus.out_zero),  32'd0);
        chk("rst.cnt",   32'(bus.out_cnt),   32'd0);
        reset = 1'b1;
        tick();
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);

        // 1: samples 1..8 back to back
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) begin
                send(16'(i));
                chk("t1.noval", 32'(bus.out_valid), 32'd0);
            end else begin
                send(16'(i));
            end
        end
        chk_frame("t1", 32'd36, 32'd8, 32'd0, 32'd8);
        take("t1");

        // 2: alternating 0 / 0xFFFF, full-scale sum without wrap
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 16'h0000 : 16'hFFFF);
        chk_frame("t2", 32'h3FFFC, 32'hFFFF, 32'd4, 32'd8);
        take("t2");

        // 3: partial frame closed by a lone flush, then empty flush ignored
        send(16'h0010);
        send(16'h0000);
        send(16'h0100);
        chk("t3.noval", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_frame("t3", 32'h110, 32'h100, 32'd1, 32'd3);
        take("t3");
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t3.empty_flush", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t3.empty_flush2", 32'(bus.out_valid), 32'd0);

        // 4: flush coincident with the second sample
        send(16'd5);
        bus.flush = 1'b1;
        send(16'd7);
        bus.flush = 1'b0;
        chk_frame("t4", 32'd12, 32'd7, 32'd0, 32'd2);
        take("t4");

        // 5: consumer stalls 10 cycles; input traffic must be ignored
        for (int i = 1; i <= 8; i++) send(16'(i * 10));
        chk_frame("t5", 32'd360, 32'd80, 32'd0, 32'd8);
        held_sum = bus.out_sum;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hA5A5;
            bus.flush    = (i == 3);
            tick();
            chk("t5.hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t5.hold_rdy",   32'(bus.in_ready),  32'd0);
            chk("t5.hold_sum",   32'(bus.out_sum),   32'(held_sum));
            chk("t5.hold_max",   32'(bus.out_max),   32'd80);
            chk("t5.hold_cnt",   32'(bus.out_cnt),   32'd8);
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        take("t5");
        tick();
        chk("t5.one_hs", 32'(bus.out_valid), 32'd0);
        // a single new sample proves none of the stalled traffic leaked in
        bus.flush = 1'b1;
        send(16'd9);
        bus.flush = 1'b0;
        chk_frame("t5b", 32'd9, 32'd9, 32'd0, 32'd1);
        take("t5b");

        // 6: reset mid-frame and during HOLD
        for (int i = 0; i < 5; i++) send(16'd100);
        reset = 1'b0;
        #1;
        chk("t6.mid_cnt", 32'(bus.out_cnt), 32'd0);
        chk("t6.mid_sum", 32'(bus.out_sum), 32'd0);
        #3;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(16'd50);
        chk("t6.pre_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6.hold_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.hold_sum",   32'(bus.out_sum),   32'd0);
        #3;
        reset = 1'b1;
        tick();
        chk("t6.rdy", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) send(16'd2);
        chk_frame("t6", 32'd16, 32'd2, 32'd0, 32'd8);
        take("t6");

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule
